// File: rtl/serial_adder_if.sv
// Handshake/operand bundle for serial_adder; the sub field exists only when
// SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, s, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, s, cout);
`else
    modport master (output start, a, b, cin, input busy, done, s, cout);
    modport slave  (input start, a, b, cin, output busy, done, s, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder: BITS_PER_CYCLE bits per clock, LSB digit first, one
// registered carry. Optional subtract mode under SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic           clk,
    input logic           rst,
    serial_adder_if.slave bus
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state_reg, state_next;
    logic [WIDTH-1:0]      a_sh_reg, b_sh_reg, s_reg;
    logic                  carry_reg, cout_reg;
    logic [CW-1:0]         cnt_reg;
    logic [BITS_PER_CYCLE:0] digit;
    logic [WIDTH-1:0]      s_shift;
    logic [WIDTH-1:0]      b_load;
    logic                  carry_load;
    logic                  accept;
    logic                  last_digit;

    assign accept     = bus.start && (state_reg == IDLE || state_reg == DONE);
    assign last_digit = (state_reg == RUN) && (cnt_reg == CW'(N - 1));

    // Subtraction is a + ~b + 1, so only the loaded b and seed carry differ.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = bus.sub ? ~bus.b : bus.b;
    assign carry_load = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_load     = bus.b;
    assign carry_load = bus.cin;
`endif

    assign digit = {1'b0, a_sh_reg[BITS_PER_CYCLE-1:0]}
                 + {1'b0, b_sh_reg[BITS_PER_CYCLE-1:0]}
                 + {{BITS_PER_CYCLE{1'b0}}, carry_reg};

    // New digit enters at the top so after N digits the sum is LSB-aligned.
    assign s_shift = (s_reg >> BITS_PER_CYCLE)
                   | (WIDTH'(digit[BITS_PER_CYCLE-1:0]) << (WIDTH - BITS_PER_CYCLE));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_digit) state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_sh_reg  <= bus.a;
                b_sh_reg  <= b_load;
                carry_reg <= carry_load;
                cnt_reg   <= '0;
            end else if (state_reg == RUN) begin
                a_sh_reg  <= a_sh_reg >> BITS_PER_CYCLE;
                b_sh_reg  <= b_sh_reg >> BITS_PER_CYCLE;
                carry_reg <= digit[BITS_PER_CYCLE];
                s_reg     <= s_shift;
                cnt_reg   <= cnt_reg + CW'(1);
                if (last_digit)
                    cout_reg <= digit[BITS_PER_CYCLE];
            end
        end
    end

    assign bus.busy = (state_reg == RUN);
    assign bus.done = (state_reg == DONE);
    assign bus.s    = s_reg;
    assign bus.cout = cout_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 at BPC 1/4 and exhaustive WIDTH=4
// at BPC 1/2/4, all sharing one clock and reset.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       start4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;

    int n_cmp = 0;
    int n_err = 0;

    serial_adder_if #(.WIDTH(8)) bus8_1 ();
    serial_adder_if #(.WIDTH(8)) bus8_4 ();
    serial_adder_if #(.WIDTH(4)) bus4_1 ();
    serial_adder_if #(.WIDTH(4)) bus4_2 ();
    serial_adder_if #(.WIDTH(4)) bus4_4 ();

    assign bus8_1.start = start8; assign bus8_1.a = a8; assign bus8_1.b = b8; assign bus8_1.cin = cin8;
    assign bus8_4.start = start8; assign bus8_4.a = a8; assign bus8_4.b = b8; assign bus8_4.cin = cin8;
    assign bus4_1.start = start4; assign bus4_1.a = a4; assign bus4_1.b = b4; assign bus4_1.cin = cin4;
    assign bus4_2.start = start4; assign bus4_2.a = a4; assign bus4_2.b = b4; assign bus4_2.cin = cin4;
    assign bus4_4.start = start4; assign bus4_4.a = a4; assign bus4_4.b = b4; assign bus4_4.cin = cin4;
`ifdef SERIAL_ADDER_SUB_EN
    assign bus8_1.sub = sub8; assign bus8_4.sub = sub8;
    assign bus4_1.sub = 1'b0; assign bus4_2.sub = 1'b0; assign bus4_4.sub = 1'b0;
`endif

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8_1 (.clk(clk), .rst(rst), .bus(bus8_1));
    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut8_4 (.clk(clk), .rst(rst), .bus(bus8_4));
    serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(1)) dut4_1 (.clk(clk), .rst(rst), .bus(bus4_1));
    serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(2)) dut4_2 (.clk(clk), .rst(rst), .bus(bus4_2));
    serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(4)) dut4_4 (.clk(clk), .rst(rst), .bus(bus4_4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Per-operation observations for the two WIDTH=8 instances.
    int         lat1, lat4, busy1, busy4, overlap;
    logic [8:0] res1, res4;

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sb);
        a8 = a; b8 = b; cin8 = c; sub8 = sb; start8 = 1'b1;
        lat1 = 0; lat4 = 0; busy1 = 0; busy4 = 0; overlap = 0;
        res1 = 'x; res4 = 'x;
        tick();
        start8 = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            if (e > 1) tick();
            if (bus8_1.busy) busy1++;
            if (bus8_4.busy) busy4++;
            if (bus8_1.busy && bus8_1.done) overlap++;
            if (bus8_4.busy && bus8_4.done) overlap++;
            if (bus8_1.done && lat1 == 0) begin lat1 = e; res1 = {bus8_1.cout, bus8_1.s}; end
            if (bus8_4.done && lat4 == 0) begin lat4 = e; res4 = {bus8_4.cout, bus8_4.s}; end
        end
        $display("op a=%h b=%h cin=%b sub=%b -> bpc1 %h @%0d bpc4 %h @%0d", a, b, c, sb, res1, lat1, res4, lat4);
    endtask

    initial begin
        logic [4:0] r1, r2, r4, exp5;
        int         dones, first_lat, second_lat;
        logic [8:0] first_res, second_res;

        // Reset state
        tick(); tick(); tick();
        check("reset_busy", 16'(bus8_1.busy), 16'd0);
        check("reset_done", 16'(bus8_1.done), 16'd0);
        check("reset_s",    16'(bus8_1.s),    16'd0);
        check("reset_cout", 16'(bus8_1.cout), 16'd0);
        check("reset_s4",   16'({bus4_4.cout, bus4_4.s}), 16'd0);
        rst = 1'b0;
        tick();

        // Abort mid-RUN after three digits of 0xAA + 0x55
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        check("midrun_busy", 16'(bus8_1.busy), 16'd1);
        check("midrun_s",    16'(bus8_1.s),    16'h00E0);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 16'(bus8_1.busy), 16'd0);
        check("abort_s",    16'(bus8_1.s),    16'd0);
        check("abort_cout", 16'(bus8_1.cout), 16'd0);
        tick();
        rst = 1'b0;
        dones = 0;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (bus8_1.done || bus8_1.busy) dones++;
        end
        $display("abort: activity after reset = %0d", dones);
        check("abort_no_done", 16'(dones), 16'd0);

        // 0xFF + 0x01: carry ripples the full width
        run8(8'hFF, 8'h01, 1'b0, 1'b0);
        check("ff01_res1",  16'(res1),  16'h0100);
        check("ff01_lat1",  16'(lat1),  16'd9);
        check("ff01_busy1", 16'(busy1), 16'd8);
        check("ff01_res4",  16'(res4),  16'h0100);

        // 0x3C + 0x0F + 1 at BPC=4
        run8(8'h3C, 8'h0F, 1'b1, 1'b0);
        check("3c0f_res4",  16'(res4),  16'h004C);
        check("3c0f_lat4",  16'(lat4),  16'd3);
        check("3c0f_busy4", 16'(busy4), 16'd2);
        check("3c0f_res1",  16'(res1),  16'h004C);
        check("busy_done_overlap", 16'(overlap), 16'd0);

        // Start held high: back-to-back accept in DONE; operands change during RUN
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        first_lat = 0; second_lat = 0; first_res = 'x; second_res = 'x; overlap = 0;
        tick();
        for (int e = 1; e <= 24; e++) begin
            if (e > 1) tick();
            if (e == 3) begin a8 = 8'h01; b8 = 8'h02; end
            if (bus8_1.busy && bus8_1.done) overlap++;
            if (bus8_1.done) begin
                if (first_lat == 0) begin
                    first_lat = e; first_res = {bus8_1.cout, bus8_1.s};
                end else if (second_lat == 0) begin
                    second_lat = e; second_res = {bus8_1.cout, bus8_1.s};
                    start8 = 1'b0;
                end
            end
        end
        $display("b2b: first %h @%0d second %h @%0d", first_res, first_lat, second_res, second_lat);
        check("b2b_first_res",  16'(first_res),  16'h0030);
        check("b2b_first_lat",  16'(first_lat),  16'd9);
        check("b2b_second_res", 16'(second_res), 16'h0003);
        check("b2b_second_lat", 16'(second_lat), 16'd18);
        check("b2b_overlap",    16'(overlap),    16'd0);
        check("b2b_idle_busy",  16'(bus8_1.busy), 16'd0);
        check("b2b_s_held",     16'({bus8_1.cout, bus8_1.s}), 16'h0003);

`ifdef SERIAL_ADDER_SUB_EN
        run8(8'h05, 8'h07, 1'b0, 1'b1);
        check("sub_5m7_res1", 16'(res1), 16'h00FE);
        check("sub_5m7_res4", 16'(res4), 16'h00FE);
        run8(8'h07, 8'h05, 1'b1, 1'b1);
        check("sub_7m5_res1", 16'(res1), 16'h0102);
        check("sub_7m5_res4", 16'(res4), 16'h0102);
`endif

        // Exhaustive WIDTH=4 across BPC 1, 2 and 4
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
                    r1 = 'x; r2 = 'x; r4 = 'x;
                    tick();
                    start4 = 1'b0;
                    for (int e = 1; e <= 7; e++) begin
                        if (e > 1) tick();
                        if (bus4_1.done) r1 = {bus4_1.cout, bus4_1.s};
                        if (bus4_2.done) r2 = {bus4_2.cout, bus4_2.s};
                        if (bus4_4.done) r4 = {bus4_4.cout, bus4_4.s};
                    end
                    exp5 = 5'(ia + ib + ic);
                    $display("w4 a=%h b=%h cin=%0d -> %h %h %h exp %h", ia[3:0], ib[3:0], ic, r1, r2, r4, exp5);
                    check("w4_bpc1", 16'(r1), 16'(exp5));
                    check("w4_bpc2", 16'(r2), 16'(exp5));
                    check("w4_bpc4", 16'(r4), 16'(exp5));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
